// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-divide step per clock.
// Optional macro MULDIV_EARLY_OUT_EN lets special cases skip the iteration phase.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             sign,
    output logic             div_by_zero
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]         state_q;
    logic [2:0]         op_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [CW-1:0]      cnt_q;
    logic               sa_q;
    logic               sb_q;
    logic               special_q;
    logic [WIDTH-1:0]   special_val_q;
    logic               dbz_q;

    // Accept-stage decode
    logic             is_div;
    logic             a_signed;
    logic             b_signed;
    logic             sa;
    logic             sb;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic             dbz_in;
    logic             ovf_in;
    logic             mul_zero;
    logic             special_in;
    logic [WIDTH-1:0] special_val;

    always_comb begin
        is_div   = op[2];
        a_signed = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
        b_signed = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
        sa       = a_signed & src_a[WIDTH-1];
        sb       = b_signed & src_b[WIDTH-1];
        mag_a    = sa ? (~src_a + 1'b1) : src_a;
        mag_b    = sb ? (~src_b + 1'b1) : src_b;
        dbz_in   = is_div & (src_b == '0);
        // Only signed DIV/REM (op[0] == 0) can overflow.
        ovf_in   = is_div & ~op[0] & (src_a == MOST_NEG) & (&src_b);
        mul_zero = ~is_div & ((src_a == '0) | (src_b == '0));
        special_in  = dbz_in | ovf_in | mul_zero;
        special_val = '0;
        if (dbz_in) begin
            special_val = op[1] ? src_a : {WIDTH{1'b1}};
        end else if (ovf_in) begin
            special_val = op[1] ? '0 : MOST_NEG;
        end
    end

    // Iteration datapath; acc_q holds {hi, lo} for both multiply and divide.
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH:0]       div_diff;
    logic [2*WIDTH-1:0]   div_next;
    logic [2*WIDTH-1:0]   acc_next;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     quot;
    logic [WIDTH-1:0]     remv;
    logic [WIDTH-1:0]     calc_val;
    logic [WIDTH-1:0]     final_val;
    logic                 last;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
        mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
        div_shift = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff  = div_shift - {1'b0, opnd_q};
        if (div_diff[WIDTH]) begin
            div_next = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
            div_next = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end
        acc_next = op_q[2] ? div_next : mul_next;

        prod = (sa_q ^ sb_q) ? (~acc_next + 1'b1) : acc_next;
        quot = (sa_q ^ sb_q) ? (~acc_next[WIDTH-1:0] + 1'b1) : acc_next[WIDTH-1:0];
        remv = sa_q ? (~acc_next[2*WIDTH-1:WIDTH] + 1'b1) : acc_next[2*WIDTH-1:WIDTH];

        if (op_q[2]) begin
            calc_val = op_q[1] ? remv : quot;
        end else begin
            calc_val = (op_q[1:0] == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
        end
        final_val = special_q ? special_val_q : calc_val;
        last      = (cnt_q == CW'(WIDTH - 1));
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            op_q          <= '0;
            acc_q         <= '0;
            opnd_q        <= '0;
            cnt_q         <= '0;
            sa_q          <= 1'b0;
            sb_q          <= 1'b0;
            special_q     <= 1'b0;
            special_val_q <= '0;
            dbz_q         <= 1'b0;
            result        <= '0;
            zero          <= 1'b0;
            sign          <= 1'b0;
            div_by_zero   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_q          <= op;
                        sa_q          <= sa;
                        sb_q          <= sb;
                        special_q     <= special_in;
                        special_val_q <= special_val;
                        dbz_q         <= dbz_in;
                        cnt_q         <= '0;
                        acc_q         <= {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
                        opnd_q        <= is_div ? mag_b : mag_a;
`ifdef MULDIV_EARLY_OUT_EN
                        if (special_in) begin
                            result      <= special_val;
                            zero        <= (special_val == '0);
                            sign        <= special_val[WIDTH-1];
                            div_by_zero <= dbz_in;
                            state_q     <= ST_DONE;
                        end else begin
                            state_q     <= ST_CALC;
                        end
`else
                        state_q       <= ST_CALC;
`endif
                    end
                end
                ST_CALC: begin
                    acc_q <= acc_next;
                    cnt_q <= cnt_q + 1'b1;
                    if (last) begin
                        result      <= final_val;
                        zero        <= (final_val == '0);
                        sign        <= final_val[WIDTH-1];
                        div_by_zero <= dbz_q;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit at WIDTH = 32.
module tb_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        sign;
    logic        div_by_zero;

    int checks;
    int errors;

`ifdef MULDIV_EARLY_OUT_EN
    localparam int SPECIAL_LAT = 0;
`else
    localparam int SPECIAL_LAT = 32;
`endif

    muldiv_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .src_a      (src_a),
        .src_b      (src_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .zero       (zero),
        .sign       (sign),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one request for one edge; caller must be in IDLE.
    task automatic start_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        op       = o;
        src_a    = a;
        src_b    = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Count edges after the accept edge until out_valid is seen.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic z, output logic s,
                         output logic d, output int lat);
        start_op(o, a, b);
        wait_valid(lat);
        r = result;
        z = zero;
        s = sign;
        d = div_by_zero;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        in_valid  = 1'b1;
        op        = 3'b000;
        src_a     = 32'd3;
        src_b     = 32'd4;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs ready=%b valid=%b want ready=1 valid=0", in_ready, out_valid);
        end
        checks++;
        if (result !== 32'd0 || zero !== 1'b0 || sign !== 1'b0 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_out result=%h z=%b s=%b d=%b want all 0",
                     result, zero, sign, div_by_zero);
        end
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ignore_valid in_ready=%b want 1", in_ready);
        end
    endtask

    task automatic test_mul;
        logic [31:0] r;
        logic z, s, d;
        int lat;
        do_op(3'b000, 32'd7, 32'hFFFF_FFFD, r, z, s, d, lat);
        checks++;
        if (r !== 32'hFFFF_FFEB || s !== 1'b1 || z !== 1'b0 || d !== 1'b0) begin
            errors++;
            $display("FAIL mul result=%h s=%b z=%b d=%b want FFFFFFEB 1 0 0", r, s, z, d);
        end
        checks++;
        if (lat !== 32) begin
            errors++;
            $display("FAIL mul_latency got=%0d want=32", lat);
        end
        do_op(3'b001, 32'h8000_0000, 32'h8000_0000, r, z, s, d, lat);
        checks++;
        if (r !== 32'h4000_0000) begin
            errors++;
            $display("FAIL mulh result=%h want 40000000", r);
        end
        do_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, z, s, d, lat);
        checks++;
        if (r !== 32'hFFFF_FFFF || s !== 1'b1) begin
            errors++;
            $display("FAIL mulhsu result=%h s=%b want FFFFFFFF 1", r, s);
        end
        do_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, z, s, d, lat);
        checks++;
        if (r !== 32'hFFFF_FFFE) begin
            errors++;
            $display("FAIL mulhu result=%h want FFFFFFFE", r);
        end
        do_op(3'b000, 32'd0, 32'd5, r, z, s, d, lat);
        checks++;
        if (r !== 32'd0 || z !== 1'b1 || d !== 1'b0 || lat !== SPECIAL_LAT) begin
            errors++;
            $display("FAIL mul_zero result=%h z=%b d=%b lat=%0d want 0 1 0 %0d",
                     r, z, d, lat, SPECIAL_LAT);
        end
    endtask

    task automatic test_div;
        logic [31:0] r;
        logic z, s, d;
        int lat;
        do_op(3'b100, 32'hFFFF_FFF9, 32'd2, r, z, s, d, lat);
        checks++;
        if (r !== 32'hFFFF_FFFD || d !== 1'b0 || lat !== 32) begin
            errors++;
            $display("FAIL div result=%h d=%b lat=%0d want FFFFFFFD 0 32", r, d, lat);
        end
        do_op(3'b110, 32'hFFFF_FFF9, 32'd2, r, z, s, d, lat);
        checks++;
        if (r !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL rem result=%h want FFFFFFFF", r);
        end
        do_op(3'b101, 32'd100, 32'd7, r, z, s, d, lat);
        checks++;
        if (r !== 32'd14 || s !== 1'b0) begin
            errors++;
            $display("FAIL divu result=%h want 0000000e", r);
        end
        do_op(3'b111, 32'd100, 32'd7, r, z, s, d, lat);
        checks++;
        if (r !== 32'd2) begin
            errors++;
            $display("FAIL remu result=%h want 00000002", r);
        end
    endtask

    task automatic test_special;
        logic [31:0] r;
        logic z, s, d;
        int lat;
        do_op(3'b100, 32'd5, 32'd0, r, z, s, d, lat);
        checks++;
        if (r !== 32'hFFFF_FFFF || d !== 1'b1 || lat !== SPECIAL_LAT) begin
            errors++;
            $display("FAIL div_by_zero result=%h d=%b lat=%0d want FFFFFFFF 1 %0d",
                     r, d, lat, SPECIAL_LAT);
        end
        do_op(3'b110, 32'hFFFF_FFF9, 32'd0, r, z, s, d, lat);
        checks++;
        if (r !== 32'hFFFF_FFF9 || d !== 1'b1) begin
            errors++;
            $display("FAIL rem_by_zero result=%h d=%b want FFFFFFF9 1", r, d);
        end
        do_op(3'b101, 32'd9, 32'd0, r, z, s, d, lat);
        checks++;
        if (r !== 32'hFFFF_FFFF || d !== 1'b1) begin
            errors++;
            $display("FAIL divu_by_zero result=%h d=%b want FFFFFFFF 1", r, d);
        end
        do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, r, z, s, d, lat);
        checks++;
        if (r !== 32'h8000_0000 || d !== 1'b0 || lat !== SPECIAL_LAT) begin
            errors++;
            $display("FAIL div_ovf result=%h d=%b lat=%0d want 80000000 0 %0d",
                     r, d, lat, SPECIAL_LAT);
        end
        do_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, r, z, s, d, lat);
        checks++;
        if (r !== 32'd0 || z !== 1'b1) begin
            errors++;
            $display("FAIL rem_ovf result=%h z=%b want 00000000 1", r, z);
        end
    endtask

    task automatic test_backpressure;
        int lat;
        out_ready = 1'b0;
        start_op(3'b101, 32'd1000, 32'd10);
        wait_valid(lat);
        checks++;
        if (out_valid !== 1'b1 || result !== 32'd100) begin
            errors++;
            $display("FAIL bp_result valid=%b result=%h want 1 00000064", out_valid, result);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 32'd100) begin
                errors++;
                $display("FAIL bp_hold cyc=%0d valid=%b ready=%b result=%h want 1 0 00000064",
                         i, out_valid, in_ready, result);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release valid=%b ready=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_midop;
        logic [31:0] r;
        logic z, s, d;
        int lat;
        start_op(3'b000, 32'd3, 32'd5);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'd0) begin
            errors++;
            $display("FAIL rst_midop valid=%b ready=%b result=%h want 0 1 00000000",
                     out_valid, in_ready, result);
        end
        do_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, z, s, d, lat);
        checks++;
        if (r !== 32'hFFFF_FFFE || lat !== 32) begin
            errors++;
            $display("FAIL rst_after_mulhu result=%h lat=%0d want FFFFFFFE 32", r, lat);
        end
    endtask

    task automatic test_back_to_back;
        int n;
        int lat;
        logic rdy;
        op       = 3'b101;
        src_a    = 32'd50;
        src_b    = 32'd5;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        n = 0;
        do begin
            rdy = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 100);
        in_valid = 1'b0;
        checks++;
        if (n !== 34) begin
            errors++;
            $display("FAIL issue_interval got=%0d want=34", n);
        end
        wait_valid(lat);
        checks++;
        if (result !== 32'd10 || lat !== 32) begin
            errors++;
            $display("FAIL b2b_result result=%h lat=%0d want 0000000a 32", result, lat);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        in_valid  = 1'b0;
        op        = 3'b000;
        src_a     = '0;
        src_b     = '0;
        out_ready = 1'b1;
        rst       = 1'b1;
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_backpressure();
        test_reset_midop();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide execution unit: a parametrised, multi-cycle successor to the single-cycle integer ALU. It implements the full RV32M operation set over a configurable WIDTH, using one shift-add or restoring-division step per clock, with valid/ready handshakes on both input and output. It sits beside the ALU in the execute stage. The core stalls on `in_ready`/`out_valid` while an operation is in flight.

## Interface
- `WIDTH`, default 32: operand and result width; legal values are 4..64.
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `in_valid`  in  1  — operation request.
- `in_ready`  out  1  — unit can accept a request.
- `op`  in  3  — operation; encoding equals RV32M funct3.
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `src_a`  in  WIDTH  — multiplicand or dividend.
- `src_b`  in  WIDTH  — multiplier or divisor.
- `out_valid`  out  1  — `result` and flags are valid.
- `out_ready`  in  1  — consumer accepts the result.
- `result`  out  WIDTH  — operation result.
- `zero`  out  1  — `result == 0`.
- `sign`  out  1  — `result[WIDTH-1]`.
- `div_by_zero`  out  1  — divide/remainder op with `src_b == 0`.

## Operation
- States: IDLE, CALC, DONE.
- `in_ready` = (state == IDLE).
- `out_valid` = (state == DONE).
- IDLE: on `in_valid && in_ready`:
  - latch `op`, detect special cases, load operand magnitudes, clear iteration counter, go to CALC.
  - For MULHSU, `src_a` is signed and `src_b` is unsigned.
  - For DIV/REM/MULH, both operands are signed.
  - All other ops treat both operands as unsigned.
- CALC: one iteration per cycle for WIDTH cycles.
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring step producing WIDTH quotient bits and a WIDTH remainder.
- Final CALC edge:
  - Sign fixup: negate the product if operand signs differ; negate the quotient if signs differ; the remainder takes the dividend's sign.
  - Select the output: MUL gets the low half, MULH* get the high half, DIV* get the quotient, REM* get the remainder.
  - Register `result` and the flags, then go to DONE.
- DONE: outputs are held stable until `out_ready`, then go to IDLE.
- `in_ready` stays low in DONE. A new op is accepted no earlier than the cycle after the output handshake.
- Special cases override the computed value regardless of the macro:
  - Divide by zero: DIV/DIVU give all ones; REM/REMU give `src_a`; `div_by_zero` = 1.
  - Signed overflow (DIV/REM with `src_a` = most-negative and `src_b` = all ones): DIV gives most-negative; REM gives 0.
- `div_by_zero` is 0 for all multiply ops.
- Reset: `rst` in any state returns to IDLE and discards the in-flight op. Reset values:
  - `out_valid` 0 and `in_ready` 1 (state IDLE).
  - `result` 0, `zero` 0, `sign` 0, `div_by_zero` 0.
  - Accumulators and counter 0.
- `in_valid` seen in the same cycle as `rst` is ignored.

## Timing
- Accept edge E0.
- CALC iterations occur on edges E1..E_WIDTH.
- `out_valid` is high from the cycle after edge E_WIDTH (WIDTH=32: high after the 32nd edge following acceptance).
- Minimum issue interval, with `out_ready` tied high: WIDTH+2 cycles.
- `result` changes only on the final CALC edge or on reset.
- `in_ready` is combinational from state only; there is no combinational path from inputs to outputs.

## Configuration
- Macro: `MULDIV_EARLY_OUT_EN`.
- Defined: the following go directly IDLE→DONE on the accept edge, with `out_valid` high one cycle after acceptance:
  - divide by zero;
  - signed overflow;
  - any multiply with a zero operand (result 0).
- Undefined: every op takes the full WIDTH-cycle CALC latency. Result values are identical in both builds.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3), WIDTH=32 → `result` 0xFFFFFFEB, `sign` 1, `out_valid` 32 cycles after accept.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF; MULHU same operands → 0xFFFFFFFE.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD; REM → 0xFFFFFFFF; DIVU 100 / 7 → 14; REMU → 2.
- Special cases, divide by zero:
  - DIV 5 / 0 → 0xFFFFFFFF with `div_by_zero` 1.
  - REM 0xFFFFFFF9 / 0 → 0xFFFFFFF9.
- Special cases, overflow: DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0, `zero` 1.
- Special-case latency: 1 cycle with `MULDIV_EARLY_OUT_EN` defined, 32 cycles without.
- Backpressure and reset:
  - Hold `out_ready` low 5 cycles in DONE → `result` stable, `in_ready` 0; accept completes on `out_ready`.
  - Assert `rst` at CALC iteration 10 → next cycle IDLE, `out_valid` 0, `result` 0; a following MULHU completes normally.
